// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with valid/ready on both sides,
// registered occupancy/almost-full and sticky overflow/underflow flags.
module sync_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AFULL_LVL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              afull_q, afull_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push, pop;

  // Full/empty come only from count, never from pointer comparison.
  assign in_ready    = (count_q != FULL_CNT) && !rst;
  assign out_valid   = (count_q != '0) && !rst;
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_data    = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = afull_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

  // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (in_valid && !in_ready && !rst) ovf_d = 1'b1;
    if (out_ready && !out_valid && !rst) unf_d = 1'b1;

    afull_d = (count_d >= AFULL_CNT);
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; out_valid masks stale words.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: table-driven vectors plus hand-written
// fill/overflow/drain and streaming sequences, with a data scoreboard queue.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;
  logic       almost_full;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb_q [$];

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [3:0] e_cnt;
    logic       e_af;
    logic       e_of;
    logic       e_uf;
  } vec_t;

  vec_t tbl [$];

  sync_fifo #(.DATA_W(8), .DEPTH(8), .AFULL_LVL(6)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic r, input logic iv, input logic [7:0] d,
                             input logic ordy, input logic e_ir, input logic e_ov,
                             input logic [3:0] e_cnt, input logic e_af,
                             input logic e_of, input logic e_uf);
    vec_t x;
    x.rst = r; x.iv = iv; x.din = d; x.ordy = ordy;
    x.e_ir = e_ir; x.e_ov = e_ov; x.e_cnt = e_cnt;
    x.e_af = e_af; x.e_of = e_of; x.e_uf = e_uf;
    return x;
  endfunction

  // Drive one cycle: check pre-edge handshake outputs and head data, update
  // the scoreboard from the expected handshake, then check post-edge state.
  task automatic step(input string tag, input vec_t x);
    rst       = x.rst;
    in_valid  = x.iv;
    in_data   = x.din;
    out_ready = x.ordy;
    #2;
    check({tag, " in_ready"},  in_ready,  x.e_ir);
    check({tag, " out_valid"}, out_valid, x.e_ov);
    if (x.e_ov && sb_q.size() > 0) check({tag, " out_data"}, out_data, sb_q[0]);
    if (x.rst) sb_q.delete();
    else begin
      if (x.ordy && x.e_ov && sb_q.size() > 0) void'(sb_q.pop_front());
      if (x.iv && x.e_ir) sb_q.push_back(x.din);
    end
    @(posedge clk);
    #1;
    check({tag, " count"},       count,       x.e_cnt);
    check({tag, " almost_full"}, almost_full, x.e_af);
    check({tag, " overflow"},    overflow,    x.e_of);
    check({tag, " underflow"},   underflow,   x.e_uf);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) step($sformatf("row%0d", i), tbl[i]);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //            rst iv  din    ordy ir  ov  cnt af of uf
    // reset
    tbl.push_back(v(1, 0, 8'h00, 0,   0,  0,  0,  0, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 0,   0,  0,  0,  0, 0, 0));
    // push three with consumer stalled
    tbl.push_back(v(0, 1, 8'h11, 0,   1,  0,  1,  0, 0, 0));
    tbl.push_back(v(0, 1, 8'h22, 0,   1,  1,  2,  0, 0, 0));
    tbl.push_back(v(0, 1, 8'h33, 0,   1,  1,  3,  0, 0, 0));
    // pop three
    tbl.push_back(v(0, 0, 8'h00, 1,   1,  1,  2,  0, 0, 0));
    tbl.push_back(v(0, 0, 8'h00, 1,   1,  1,  1,  0, 0, 0));
    tbl.push_back(v(0, 0, 8'h00, 1,   1,  1,  0,  0, 0, 0));
    tbl.push_back(v(0, 0, 8'h00, 0,   1,  0,  0,  0, 0, 0));
    // (index 9) push to count 5; overflow is still sticky from the full test
    tbl.push_back(v(0, 1, 8'hB1, 0,   1,  1,  2,  0, 1, 0));
    tbl.push_back(v(0, 1, 8'hB2, 0,   1,  1,  3,  0, 1, 0));
    tbl.push_back(v(0, 1, 8'hB3, 0,   1,  1,  4,  0, 1, 0));
    tbl.push_back(v(0, 1, 8'hB4, 0,   1,  1,  5,  0, 1, 0));
    // reset with a concurrent write and read attempt
    tbl.push_back(v(1, 1, 8'hEE, 1,   0,  0,  0,  0, 0, 0));
    tbl.push_back(v(0, 0, 8'h00, 0,   1,  0,  0,  0, 0, 0));
    // underflow from empty, then sticky across normal traffic
    tbl.push_back(v(0, 0, 8'h00, 1,   1,  0,  0,  0, 0, 1));
    tbl.push_back(v(0, 1, 8'h55, 0,   1,  0,  1,  0, 0, 1));
    tbl.push_back(v(0, 1, 8'h66, 1,   1,  1,  1,  0, 0, 1));
    tbl.push_back(v(0, 0, 8'h00, 1,   1,  1,  0,  0, 0, 1));
    tbl.push_back(v(1, 0, 8'h00, 1,   0,  0,  0,  0, 0, 0));
    tbl.push_back(v(0, 0, 8'h00, 0,   1,  0,  0,  0, 0, 0));

    run_rows(0, 9);

    // Fill to full with 0xA0..0xA7; almost_full from count 6.
    for (int i = 0; i < 8; i++)
      step($sformatf("fill%0d", i),
           v(0, 1, 8'hA0 + 8'(i), 0, 1, (i > 0), 4'(i + 1), (i + 1 >= 6), 0, 0));
    step("ovf_push", v(0, 1, 8'hFF, 0, 0, 1, 8, 1, 1, 0));
    // Pop while full with a push attempt: no slot opens in the same cycle.
    step("full_pop", v(0, 1, 8'hFF, 1, 0, 1, 7, 1, 1, 0));
    for (int j = 0; j < 7; j++)
      step($sformatf("drain%0d", j),
           v(0, 0, 8'h00, 1, 1, 1, 4'(6 - j), (6 - j >= 6), 1, 0));
    step("drained", v(0, 0, 8'h00, 0, 1, 0, 0, 0, 1, 0));

    // Streaming at count 1 for 20 cycles; pointers wrap past 7 twice.
    step("stream_seed", v(0, 1, 8'h00, 0, 1, 0, 1, 0, 1, 0));
    for (int k = 0; k < 20; k++)
      step($sformatf("stream%0d", k), v(0, 1, 8'(k + 1), 1, 1, 1, 1, 0, 1, 0));

    run_rows(9, tbl.size());

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Synchronous first-word-fall-through FIFO buffer built from the flip-flop storage primitives in the memory library. It sits directly downstream of the register or flip-flop stage that produces data, decoupling that producer from a consumer that may stall. Both sides use a valid/ready handshake, and occupancy is reported so upstream logic can throttle.

## Interface
Parameters:
- DATA_W, 8, width of each stored word
- DEPTH, 8, number of entries; must be a power of two and at least 2
- AFULL_LVL, DEPTH-2, occupancy at or above which almost_full asserts; range 1..DEPTH

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock for all state
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk
- in_data  input  DATA_W  write word
- in_valid  input  1  producer offers in_data
- in_ready  output  1  FIFO can accept a word this cycle
- out_data  output  DATA_W  head-of-queue word; valid only when out_valid=1
- out_valid  output  1  FIFO holds at least one word
- out_ready  input  1  consumer takes out_data this cycle
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- almost_full  output  1  count >= AFULL_LVL
- overflow  output  1  sticky: in_valid was seen while in_ready=0
- underflow  output  1  sticky: out_ready was seen while out_valid=0

## Operation
- Storage: DEPTH x DATA_W register array. There is no reset of the array contents.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits each and wrap modulo DEPTH naturally.
  - The count register is kept separately and is the sole source of the full and empty flags.
- Push: occurs when in_valid && in_ready. mem[wr_ptr] <= in_data, then wr_ptr increments.
- Pop: occurs when out_valid && out_ready. rd_ptr increments.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged. Both pointers advance.
- Combinational outputs:
  - in_ready = (count != DEPTH) && !rst.
  - out_valid = (count != 0) && !rst.
  - out_data = mem[rd_ptr]; this is first-word-fall-through.
- Full: in_ready=0. A simultaneous pop does not open a slot in the same cycle; there is no full-bypass path.
- Empty: out_valid=0. A simultaneous push is stored, and the word is not forwarded in the same cycle; there is no empty-bypass path.
- Error flags:
  - overflow sets on in_valid && !in_ready outside reset.
  - underflow sets on out_ready && !out_valid outside reset.
  - Both flags hold until rst. A rejected attempt never alters storage, pointers or count.
- Reset: rst=1 at a clock edge sets wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
  - While rst is high, in_ready=0 and out_valid=0, and no push or pop occurs.
  - Reset mid-operation discards all queued words. The stale array contents are never presented, because out_valid stays 0 until a new push.

## Timing
- Reset values of outputs:
  - in_ready=0 while rst is high; 1 on the first cycle after release.
  - out_valid=0, count=0, almost_full=0, overflow=0, underflow=0.
  - out_data is don't-care.
- Write-to-read latency: 1 cycle. A word pushed at edge N appears on out_data with out_valid=1 in the cycle after edge N.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- count, almost_full and the sticky flags are registered and update at the edge of the triggering handshake.
- Ordering: strict FIFO order is preserved across pointer wrap-around.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 with out_ready=0 -> count=3; out_data=0x11 one cycle after the first push; in_ready=1.
- With out_ready=1, pop three words -> out_data sequence 0x11, 0x22, 0x33; count reaches 0; out_valid=0 afterwards; underflow stays 0.
- Fill to 8 words (0xA0..0xA7) -> in_ready=0 and almost_full=1 from count=6. Then drive in_valid=1 with 0xFF -> overflow=1 and count stays 8. Drain all words -> 0xA0..0xA7 in order, with no 0xFF.
- Hold in_valid=1 and out_ready=1 continuously for 20 cycles, starting from count=1, with incrementing data -> count stays 1, data emerges in order, and both pointers wrap past 7 at least twice.
- At count=5, assert rst for one cycle together with in_valid=1 -> the next cycle shows count=0, out_valid=0, overflow=0, and the concurrent word is not stored.
- From empty, drive out_ready=1 with in_valid=0 -> underflow=1 and stays 1 across subsequent normal traffic until rst.
